dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the pipeline memory stage and DataMemory.
- Read hits complete in the same cycle.
- Read misses and all writes run one DataMemory transaction (valid/rw/ready handshake), then give one cycle of valid-low gap.
- Word-addressed, one 32-bit word per line.

Parameters:
- NUM_LINES, 16, number of cache lines; power of two, at least 2.
- IDX_W, log2(NUM_LINES), index width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  request valid; held with addr/we/wdata stable until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  word address.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid only when cpu_ready=1 and cpu_we=0.
- cpu_ready  out  1  request completes this cycle.
- mem_valid  out  1  DataMemory valid.
- mem_rw  out  1  DataMemory rw (1 = write).
- mem_addr  out  32  DataMemory addr (= cpu_addr).
- mem_wr_data  out  32  DataMemory wr_data (= cpu_wdata).
- mem_rd_data  in  32  DataMemory rd_data; valid only with mem_ready.
- mem_ready  in  1  DataMemory ready; one-cycle pulse.

Behaviour:
- Address split: index = cpu_addr[IDX_W-1:0], tag = cpu_addr[31:IDX_W].
- hit = cpu_req & valid[index] & (tag_mem[index] == tag).
- Reset (async, rst_n=0):
  - state=IDLE, all valid bits 0, mem_valid=0, mem_rw=0, cpu_ready=0.
  - cpu_rdata=0 and fill register=0.
  - Tag and data arrays are not reset.
- FSM states: IDLE, MEM_RD, MEM_WR, RESP.
- IDLE:
  - Load hit: cpu_ready=1 combinationally and cpu_rdata=data_mem[index]; stay IDLE. Latency is 0 cycles.
  - Load miss: go to MEM_RD.
  - Store (hit or miss): go to MEM_WR.
  - No request: stay IDLE.
  - mem_valid=0.
- MEM_RD:
  - Drive mem_valid=1, mem_rw=0.
  - On mem_ready=1: write mem_rd_data into data[index], tag into tag[index], set valid[index]=1, latch mem_rd_data into the fill register, go to RESP.
- MEM_WR:
  - Drive mem_valid=1, mem_rw=1.
  - On mem_ready=1: if the line hits, update data[index] with cpu_wdata (no allocate on a miss), go to RESP.
- RESP:
  - mem_valid=0, cpu_ready=1.
  - cpu_rdata = fill register for loads, 0 for stores.
  - Unconditionally go to IDLE.
- Handshake rules:
  - mem_valid, once asserted, stays high until the cycle mem_ready is seen.
  - mem_valid is low for at least one cycle (RESP) between transactions. DataMemory's stall counter needs this gap to reset.
  - mem_addr and mem_wr_data are a pass-through of cpu_addr and cpu_wdata. The CPU must hold them stable.
  - mem_rw is a registered copy of the state decode; no glitch while mem_valid=1.
- Miss timing: cpu_ready rises exactly one cycle after the cycle with mem_ready=1.
- Boundary cases:
  - mem_ready while in IDLE or RESP: ignored, no array update.
  - cpu_req dropped mid-transaction: the transaction completes and the fill/update still happens. The RESP cpu_ready pulse is issued and ignored by the CPU.
  - Same-index, different-tag load miss: the old line is overwritten (the cache is write-through, so it is never dirty).
  - Load immediately after a store to the same address: hits with the new data if that line was resident. Otherwise it misses and memory returns the new data.
  - Reset mid-transaction: mem_valid drops asynchronously and all lines are invalidated. The pending CPU request is lost; the CPU must reissue it.
  - Any address bits beyond memory depth are passed through unchanged (DataMemory decodes them).

Decomposition:
- Shared include dcache_defs.vh holds:
  - state encodings S_IDLE=2'd0, S_MEM_RD=2'd1, S_MEM_WR=2'd2, S_RESP=2'd3;
  - the log2 function used for IDX_W.
- One sub-module, dcache_array:
  - contains the NUM_LINES valid flops (async reset to 0), tag RAM and data RAM;
  - combinational read port (hit, rdata);
  - single write port (we, idx, tag, data, set_valid).
- dcache_ctrl holds the FSM, the fill register and output muxing.

Test Plan:
- Common setup: DataMemory NUM_CLK_CYCLES=2 for all scenarios.
- Reset then load addr 0x1: miss, mem_valid=1 with mem_rw=0 until mem_ready, cpu_rdata=0x1 in the RESP cycle, mem_valid=0 in that cycle. A repeat load of 0x1 gives cpu_ready=1 in the same cycle with no mem_valid.
- Store 0x5 to 0x21 (line not resident), then load 0x21: the store produces one mem_rw=1 transaction. The load misses (no allocate) and returns 0x5.
- Load 0x3 (fill), store 0xAA to 0x3, load 0x3: the store goes to memory and updates the line. The final load hits in 0 cycles with cpu_rdata=0xAA.
- Conflict (NUM_LINES=16): load 0x02 then load 0x12 then load 0x02. All three miss, each separated by a mem_valid-low cycle, and the data matches memory.
- Back-to-back: 4 consecutive load misses to 0x4..0x7. Check mem_valid is never high across a RESP cycle, and each cpu_ready comes exactly 1 cycle after mem_ready.
- Assert rst_n=0 during MEM_RD: mem_valid=0 immediately, no cpu_ready. After release, load of the previously cached address misses.

Source files
------------

// File: rtl/dcache_ctrl_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
package dcache_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MEM_RD = 2'd1,
    S_MEM_WR = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid flops plus tag/data storage; combinational lookup, single write port.
module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned TAG_W     = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  tag,
  output logic              hit_c,
  output logic [DATA_W-1:0] rdata_c,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              set_valid
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [DATA_W-1:0]    data_mem [NUM_LINES];

  assign hit_c   = valid_q[idx] && (tag_mem[idx] == tag);
  assign rdata_c = data_mem[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (we && set_valid) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Storage arrays carry no reset; valid_q gates their contents.
  always_ff @(posedge clk) begin
    if (we) begin
      data_mem[idx] <= wdata;
      if (set_valid) tag_mem[idx] <= tag;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LINES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_ready
);

  localparam int unsigned IDX_W = clog2(NUM_LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   fill_q;
  logic                line_hit_c, hit_c;
  logic [DATA_W-1:0]   line_data_c;
  logic                arr_we, arr_set_valid;
  logic [DATA_W-1:0]   arr_wdata;

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (cpu_addr[IDX_W-1:0]),
    .tag       (cpu_addr[ADDR_W-1:IDX_W]),
    .hit_c     (line_hit_c),
    .rdata_c   (line_data_c),
    .we        (arr_we),
    .wdata     (arr_wdata),
    .set_valid (arr_set_valid)
  );

  assign hit_c       = cpu_req && line_hit_c;
  assign mem_addr    = cpu_addr;
  assign mem_wr_data = cpu_wdata;

  // Next state and array write control; fills/updates ignore cpu_req so a dropped request still completes.
  always_comb begin
    state_d       = state_q;
    arr_we        = 1'b0;
    arr_set_valid = 1'b0;
    arr_wdata     = cpu_wdata;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (cpu_we)      state_d = S_MEM_WR;
          else if (!hit_c) state_d = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        if (mem_ready) begin
          arr_we        = 1'b1;
          arr_set_valid = 1'b1;
          arr_wdata     = mem_rd_data;
          state_d       = S_RESP;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          arr_we  = line_hit_c;
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
    endcase
  end

  // mem_valid/mem_rw decode the next state so they are glitch-free flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mem_valid <= 1'b0;
      mem_rw    <= 1'b0;
      fill_q    <= '0;
    end else begin
      state_q   <= state_d;
      mem_valid <= (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
      mem_rw    <= (state_d == S_MEM_WR);
      if ((state_q == S_MEM_RD) && mem_ready) fill_q <= mem_rd_data;
    end
  end

  assign cpu_ready = ((state_q == S_IDLE) && hit_c && !cpu_we) || (state_q == S_RESP);

  always_comb begin
    cpu_rdata = '0;
    if ((state_q == S_IDLE) && hit_c && !cpu_we) cpu_rdata = line_data_c;
    else if ((state_q == S_RESP) && !cpu_we)     cpu_rdata = fill_q;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl against a 2-cycle DataMemory model.
module tb_dcache_ctrl;

  localparam int unsigned NUM_CLK_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        mem_valid, mem_rw;
  logic [31:0] mem_addr, mem_wr_data;
  logic [31:0] mem_rd_data;
  logic        mem_ready;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  logic [31:0] dmem [256];
  int          cnt;

  always #5 clk = ~clk;

  dcache_ctrl #(.NUM_LINES(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ready   (cpu_ready),
    .mem_valid   (mem_valid),
    .mem_rw      (mem_rw),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .mem_ready   (mem_ready)
  );

  // DataMemory: ready pulses after NUM_CLK_CYCLES cycles of valid; counter clears while valid is low.
  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = 32'(i);
    cnt         = 0;
    mem_ready   = 1'b0;
    mem_rd_data = '0;
  end

  always @(posedge clk) begin
    if (!mem_valid || mem_ready) begin
      cnt       <= 0;
      mem_ready <= 1'b0;
    end else if (cnt == int'(NUM_CLK_CYCLES) - 1) begin
      cnt       <= 0;
      mem_ready <= 1'b1;
      if (mem_rw) dmem[mem_addr[7:0]] <= mem_wr_data;
      else        mem_rd_data <= dmem[mem_addr[7:0]];
    end else begin
      cnt <= cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Handshake invariants: valid holds until ready, and never overlaps a cpu_ready cycle.
  logic mv_prev = 1'b0, mr_prev = 1'b0;
  always @(negedge clk) begin
    #2;
    if (mon_en && rst_n) begin
      if (mv_prev && !mr_prev) begin
        tests++;
        assert (mem_valid === 1'b1) else begin
          fails++;
          $error("FAIL mem_valid_hold observed=%b expected=1", mem_valid);
        end
      end
      if (mem_valid === 1'b1) begin
        tests++;
        assert (cpu_ready === 1'b0) else begin
          fails++;
          $error("FAIL gap_overlap observed=%b expected=0", cpu_ready);
        end
      end
    end
    mv_prev = mem_valid;
    mr_prev = mem_ready;
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_hit, input string tag);
    int cyc, rdy_at;
    bit saw_mv, bus_bad;
    cyc = 0; rdy_at = -10; saw_mv = 1'b0; bus_bad = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    #1;
    while (cpu_ready !== 1'b1 && cyc < 40) begin
      if (mem_valid === 1'b1) begin
        saw_mv = 1'b1;
        if (mem_rw !== we || mem_addr !== addr || mem_wr_data !== wd) bus_bad = 1'b1;
      end
      if (mem_ready === 1'b1) rdy_at = cyc;
      @(negedge clk); #1;
      cyc++;
    end
    chk({tag, " ready"}, 32'(cpu_ready), 32'd1);
    if (exp_hit) begin
      chk({tag, " hit_latency"}, 32'(cyc), 32'd0);
      chk({tag, " hit_no_mem"}, 32'(saw_mv), 32'd0);
    end else begin
      chk({tag, " miss_latency"}, 32'(cyc), 32'(rdy_at + 1));
      chk({tag, " mem_txn"}, 32'(saw_mv), 32'd1);
      chk({tag, " bus_ok"}, 32'(bus_bad), 32'd0);
      chk({tag, " resp_gap"}, 32'(mem_valid), 32'd0);
    end
    chk({tag, " rdata"}, cpu_rdata, exp_rd);
  endtask

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst mem_valid", 32'(mem_valid), 32'd0);
    chk("rst mem_rw",    32'(mem_rw),    32'd0);
    chk("rst cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst cpu_rdata", cpu_rdata,      32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    cpu_req = 1'b1; cpu_addr = 32'h1;
    #1;
    chk("cold lookup ready", 32'(cpu_ready), 32'd0);
    cpu_req = 1'b0;

    access(1'b0, 32'h01, 32'h0,  32'h01, 1'b0, "ld1 miss");
    access(1'b0, 32'h01, 32'h0,  32'h01, 1'b1, "ld1 hit");

    access(1'b1, 32'h21, 32'h5,  32'h0,  1'b0, "st21 nwa");
    access(1'b0, 32'h21, 32'h0,  32'h5,  1'b0, "ld21 miss");

    access(1'b0, 32'h03, 32'h0,  32'h03, 1'b0, "ld3 fill");
    access(1'b1, 32'h03, 32'hAA, 32'h0,  1'b0, "st3 upd");
    access(1'b0, 32'h03, 32'h0,  32'hAA, 1'b1, "ld3 hit");
    chk("st3 dmem", dmem[3], 32'hAA);

    access(1'b0, 32'h02, 32'h0,  32'h02, 1'b0, "conf02 a");
    access(1'b0, 32'h12, 32'h0,  32'h12, 1'b0, "conf12");
    access(1'b0, 32'h02, 32'h0,  32'h02, 1'b0, "conf02 b");

    for (int a = 4; a < 8; a++)
      access(1'b0, 32'(a), 32'h0, 32'(a), 1'b0, "b2b");

    // Reset while a load miss is outstanding.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
    @(negedge clk); #1;
    chk("mid-rd mem_valid", 32'(mem_valid), 32'd1);
    chk("mid-rd mem_rw",    32'(mem_rw),    32'd0);
    rst_n = 1'b0;
    #1;
    chk("async rst mem_valid", 32'(mem_valid), 32'd0);
    chk("async rst cpu_ready", 32'(cpu_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; cpu_req = 1'b0;
    access(1'b0, 32'h01, 32'h0, 32'h01, 1'b0, "post-rst ld1");
    access(1'b0, 32'h07, 32'h0, 32'h07, 1'b0, "post-rst ld7");

    @(negedge clk);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
